// File: rtl/vram_text_writer.sv
// -----------------------------------------------------------------------------
// vram_text_writer
//
// Producer side of the text video RAM. Accepts a byte stream of characters on a
// valid/ready handshake and turns it into VRAM write cycles (one cell per
// cycle) at cell address row*COLS+col. Maintains a cursor, interprets control
// characters (BS, LF, FF, CR), wraps lines and blanks every newly entered row.
// The screen never scrolls: it wraps from the last row back to the top row.
//
// Optional feature (compile-time macro VRAM_TEXT_WRITER_HEX_EN):
//   adds input hex_mode. When set at the transfer edge the byte (control codes
//   included) is rendered as three cells: upper nibble, lower nibble, BLANK.
//
// Ports:
//   system_clock   in   1   sole clock
//   reset          in   1   synchronous, active-high
//   char_data      in   8   input byte
//   char_valid     in   1   char_data valid
//   hex_mode       in   1   render byte as hex (only with VRAM_TEXT_WRITER_HEX_EN)
//   char_ready     out  1   block can accept a byte this cycle
//   write_enable   out  1   VRAM write strobe, one cell per cycle
//   write_address  out  12  VRAM cell address
//   data           out  8   VRAM write data
//   cursor_col     out  7   current column
//   cursor_row     out  5   current row
//   busy           out  1   clear in progress
// -----------------------------------------------------------------------------
module vram_text_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
`ifdef VRAM_TEXT_WRITER_HEX_EN
    input  logic        hex_mode,
`endif
    output logic        char_ready,
    output logic        write_enable,
    output logic [11:0] write_address,
    output logic [7:0]  data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [12:0] TOTAL_CELLS = 13'(COLS * ROWS);
    localparam logic [12:0] LINE_CELLS  = 13'(COLS);
    localparam logic [11:0] ROW_STRIDE  = 12'(COLS);
    localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2,
        HEX_OUT    = 2'd3
    } state_t;

    state_t      state_q;
    logic        we_q;
    logic [11:0] addr_q;
    logic [7:0]  data_q;
    logic [6:0]  col_q;
    logic [4:0]  row_q;
    logic [11:0] base_q;      // row_q * COLS, tracked incrementally
    logic        busy_q;
    logic        ready_q;
    logic [12:0] cnt_q;       // clear progress: cell index within screen or line

`ifdef VRAM_TEXT_WRITER_HEX_EN
    logic [7:0]  hex_byte_q;
    logic [1:0]  hex_idx_q;   // next cell to emit: 1 = low nibble, 2 = blank, 3 = done
    logic        hex_pend_q;  // a hex rendering is in flight; CLEAR_LINE returns to it

    function automatic logic [7:0] hex_digit(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'd0, nib};
        end
        return 8'h37 + {4'd0, nib};
    endfunction
`endif

    // Combinational helpers derived from the current cursor.
    logic        accept_d;
    logic        ctrl_d;
    logic [11:0] cur_addr_d;
    logic [4:0]  row_inc_d;
    logic [11:0] base_inc_d;
    logic        put_cell_d;   // a character cell is written at the cursor this edge
    logic [7:0]  cell_code_d;

    always_comb begin
        accept_d    = char_valid && ready_q;
        ctrl_d      = (char_data == 8'h08) || (char_data == 8'h0A) ||
                      (char_data == 8'h0C) || (char_data == 8'h0D);
        cur_addr_d  = base_q + {5'd0, col_q};
        row_inc_d   = (row_q == LAST_ROW) ? 5'd0  : row_q + 5'd1;
        base_inc_d  = (row_q == LAST_ROW) ? 12'd0 : base_q + ROW_STRIDE;
        put_cell_d  = 1'b0;
        cell_code_d = char_data;
        case (state_q)
            IDLE: begin
                if (accept_d) begin
`ifdef VRAM_TEXT_WRITER_HEX_EN
                    if (hex_mode) begin
                        put_cell_d  = 1'b1;
                        cell_code_d = hex_digit(char_data[7:4]);
                    end else
`endif
                    if (!ctrl_d) begin
                        put_cell_d  = 1'b1;
                        cell_code_d = char_data;
                    end
                end
            end
`ifdef VRAM_TEXT_WRITER_HEX_EN
            HEX_OUT: begin
                if (hex_idx_q != 2'd3) begin
                    put_cell_d  = 1'b1;
                    cell_code_d = (hex_idx_q == 2'd1) ? hex_digit(hex_byte_q[3:0]) : BLANK;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q    <= CLEAR_ALL;
            we_q       <= 1'b0;
            addr_q     <= 12'd0;
            data_q     <= 8'd0;
            col_q      <= 7'd0;
            row_q      <= 5'd0;
            base_q     <= 12'd0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            cnt_q      <= 13'd0;
`ifdef VRAM_TEXT_WRITER_HEX_EN
            hex_byte_q <= 8'd0;
            hex_idx_q  <= 2'd0;
            hex_pend_q <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                CLEAR_ALL: begin
                    // One idle cycle after the last write before handing back to IDLE.
                    if (cnt_q == TOTAL_CELLS) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        col_q   <= 7'd0;
                        row_q   <= 5'd0;
                        base_q  <= 12'd0;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q[11:0];
                        data_q <= BLANK;
                        cnt_q  <= cnt_q + 13'd1;
                    end
                end

                CLEAR_LINE: begin
                    if (cnt_q == LINE_CELLS) begin
                        busy_q <= 1'b0;
`ifdef VRAM_TEXT_WRITER_HEX_EN
                        if (hex_pend_q) begin
                            state_q <= HEX_OUT;
                        end else
`endif
                        begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= base_q + cnt_q[11:0];
                        data_q <= BLANK;
                        cnt_q  <= cnt_q + 13'd1;
                    end
                end

                IDLE: begin
                    if (accept_d) begin
`ifdef VRAM_TEXT_WRITER_HEX_EN
                        if (hex_mode) begin
                            hex_byte_q <= char_data;
                            hex_idx_q  <= 2'd1;
                            hex_pend_q <= 1'b1;
                            state_q    <= HEX_OUT;
                            ready_q    <= 1'b0;
                        end else
`endif
                        begin
                            case (char_data)
                                8'h0D: col_q <= 7'd0;
                                8'h0A: begin
                                    // The new row's first blank goes out on this edge,
                                    // so the line clear needs no extra cycle.
                                    col_q   <= 7'd0;
                                    row_q   <= row_inc_d;
                                    base_q  <= base_inc_d;
                                    we_q    <= 1'b1;
                                    addr_q  <= base_inc_d;
                                    data_q  <= BLANK;
                                    cnt_q   <= 13'd1;
                                    state_q <= CLEAR_LINE;
                                    busy_q  <= 1'b1;
                                    ready_q <= 1'b0;
                                end
                                8'h08: begin
                                    if (col_q != 7'd0) begin
                                        col_q <= col_q - 7'd1;
                                    end
                                end
                                8'h0C: begin
                                    col_q   <= 7'd0;
                                    row_q   <= 5'd0;
                                    base_q  <= 12'd0;
                                    we_q    <= 1'b1;
                                    addr_q  <= 12'd0;
                                    data_q  <= BLANK;
                                    cnt_q   <= 13'd1;
                                    state_q <= CLEAR_ALL;
                                    busy_q  <= 1'b1;
                                    ready_q <= 1'b0;
                                end
                                default: begin
                                    // Printable: written by the common cell path below.
                                end
                            endcase
                        end
                    end
                end

`ifdef VRAM_TEXT_WRITER_HEX_EN
                HEX_OUT: begin
                    if (hex_idx_q == 2'd3) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        hex_pend_q <= 1'b0;
                    end else begin
                        hex_idx_q <= hex_idx_q + 2'd1;
                    end
                end
`endif

                default: begin
                    state_q <= CLEAR_ALL;
                    cnt_q   <= 13'd0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase

            // Common cell write: place the cell at the cursor and advance. A wrap
            // past the last column overrides the state chosen above and blanks the
            // newly entered row before anything else is written.
            if (put_cell_d) begin
                we_q   <= 1'b1;
                addr_q <= cur_addr_d;
                data_q <= cell_code_d;
                if (col_q == LAST_COL) begin
                    col_q   <= 7'd0;
                    row_q   <= row_inc_d;
                    base_q  <= base_inc_d;
                    cnt_q   <= 13'd0;
                    state_q <= CLEAR_LINE;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end else begin
                    col_q <= col_q + 7'd1;
                end
            end
        end
    end

    // ready is registered; the reset gate keeps it low in the very cycle reset rises.
    assign char_ready    = ready_q && !reset;
    assign write_enable  = we_q;
    assign write_address = addr_q;
    assign data          = data_q;
    assign cursor_col    = col_q;
    assign cursor_row    = row_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vram_text_writer.sv
// -----------------------------------------------------------------------------
// Testbench for vram_text_writer. A screen-level reference model (cursor plus an
// ordered list of expected VRAM writes) is advanced for every accepted byte; a
// monitor matches each observed write against that list.
// -----------------------------------------------------------------------------
module tb_vram_text_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_data = 8'd0;
    logic        char_valid = 1'b0;
    logic        hex_mode_r = 1'b0;
    logic        char_ready;
    logic        write_enable;
    logic [11:0] write_address;
    logic [7:0]  data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    always #5 clk = ~clk;

    vram_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
        .system_clock (clk),
        .reset        (reset),
        .char_data    (char_data),
        .char_valid   (char_valid),
`ifdef VRAM_TEXT_WRITER_HEX_EN
        .hex_mode     (hex_mode_r),
`endif
        .char_ready   (char_ready),
        .write_enable (write_enable),
        .write_address(write_address),
        .data         (data),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;
    int n_tx     = 0;

    int exp_addr_q[$];
    int exp_data_q[$];
    int m_col = 0;
    int m_row = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push_write(input int a, input int d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endfunction

    function automatic void push_clear_line(input int r);
        for (int c = 0; c < COLS; c++) push_write(r * COLS + c, 8'h20);
    endfunction

    function automatic void push_clear_all();
        for (int a = 0; a < CELLS; a++) push_write(a, 8'h20);
    endfunction

    function automatic void model_newline();
        m_row = (m_row + 1) % ROWS;
        push_clear_line(m_row);
    endfunction

    function automatic void model_put(input int code);
        push_write(m_row * COLS + m_col, code);
        m_col++;
        if (m_col == COLS) begin
            m_col = 0;
            model_newline();
        end
    endfunction

    function automatic int hex_char(input int nib);
        return (nib < 10) ? (8'h30 + nib) : (8'h41 + nib - 10);
    endfunction

    function automatic void model_byte(input int b, input bit hx);
        if (hx) begin
            model_put(hex_char(b / 16));
            model_put(hex_char(b % 16));
            model_put(8'h20);
        end else begin
            case (b)
                8'h0D: m_col = 0;
                8'h0A: begin m_col = 0; model_newline(); end
                8'h08: if (m_col > 0) m_col--;
                8'h0C: begin m_col = 0; m_row = 0; push_clear_all(); end
                default: model_put(b);
            endcase
        end
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (write_enable === 1'b1) begin
                prev_wr_cyc = last_wr_cyc;
                last_wr_cyc = cyc;
                if (exp_addr_q.size() == 0) begin
                    check_eq("spurious_write", {20'd0, write_address}, 32'hFFFF_FFFF);
                end else begin
                    check_eq("wr_addr", {20'd0, write_address}, exp_addr_q.pop_front());
                    check_eq("wr_data", {24'd0, data}, exp_data_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready(output int low);
        low = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && low < LIMIT) begin
            low++;
            @(negedge clk);
        end
        if (low >= LIMIT) check_eq("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b, input bit hx);
        int t;
        t = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && t < LIMIT) begin
            t++;
            @(negedge clk);
        end
        if (t >= LIMIT) check_eq("send_timeout", 0, 1);
        char_data  = b;
        char_valid = 1'b1;
        hex_mode_r = hx;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        model_byte(int'(b), hx);
        n_tx++;
        $display("tx %0d: byte 0x%02h hex=%0d -> model cursor (%0d,%0d)", n_tx, b, hx, m_col, m_row);
        if (!hx) begin
            check_eq("cursor_col", {25'd0, cursor_col}, m_col);
            check_eq("cursor_row", {27'd0, cursor_row}, m_row);
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        reset = 1'b1;
        char_valid = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_data_q.delete();
        m_col = 0;
        m_row = 0;
        push_clear_all();
        check_eq("rst_we", {31'd0, write_enable}, 0);
        check_eq("rst_addr", {20'd0, write_address}, 0);
        check_eq("rst_data", {24'd0, data}, 0);
        check_eq("rst_busy", {31'd0, busy}, 1);
        check_eq("rst_ready", {31'd0, char_ready}, 0);
        check_eq("rst_col", {25'd0, cursor_col}, 0);
        check_eq("rst_row", {27'd0, cursor_row}, 0);
        @(negedge clk);
        reset = 1'b0;
        $display("tx reset released");
    endtask

    task automatic settle_and_check(input string tag);
        int low;
        wait_ready(low);
        check_eq({tag, "_col"}, {25'd0, cursor_col}, m_col);
        check_eq({tag, "_row"}, {27'd0, cursor_row}, m_row);
        check_eq({tag, "_busy"}, {31'd0, busy}, 0);
        check_eq({tag, "_pending"}, exp_addr_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int low;
        int r;
        bit hx;
        logic [7:0] b;

        // Power-up clear: 2400 blank writes, ready rises on the 2401st edge.
        do_reset(3);
        wait_ready(low);
        check_eq("init_ready_low_cycles", low, CELLS);
        check_eq("init_pending", exp_addr_q.size(), 0);
        check_eq("init_col", {25'd0, cursor_col}, 0);
        check_eq("init_busy", {31'd0, busy}, 0);

        // Back-to-back "AB".
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        wait_ready(low);
        check_eq("ab_ready_low", low, 0);
        check_eq("ab_consecutive", last_wr_cyc - prev_wr_cyc, 1);
        check_eq("ab_col", {25'd0, cursor_col}, 2);

        // Move to (5,29) then LF wraps to the top row.
        for (int i = 0; i < 29; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
        settle_and_check("pre_lf");
        send(8'h0A, 1'b0);
        check_eq("lf_busy", {31'd0, busy}, 1);
        wait_ready(low);
        check_eq("lf_ready_low", low, COLS);
        check_eq("lf_col", {25'd0, cursor_col}, 0);
        check_eq("lf_row", {27'd0, cursor_row}, 0);
        check_eq("lf_pending", exp_addr_q.size(), 0);

        // Column 79 of row 2, printable wraps and blanks row 3.
        send(8'h0A, 1'b0);
        send(8'h0A, 1'b0);
        for (int i = 0; i < COLS - 1; i++) send(8'h30 + 8'(i % 10), 1'b0);
        send(8'h58, 1'b0);
        check_eq("wrap_col", {25'd0, cursor_col}, 0);
        check_eq("wrap_row", {27'd0, cursor_row}, 3);
        settle_and_check("wrap");

        // BS and CR at column 0 do nothing; BS after a char steps back.
        send(8'h08, 1'b0);
        send(8'h0D, 1'b0);
        check_eq("bs_cr_col", {25'd0, cursor_col}, 0);
        check_eq("bs_cr_row", {27'd0, cursor_row}, 3);
        send(8'h51, 1'b0);
        send(8'h08, 1'b0);
        settle_and_check("bs");

        // Form feed clears the whole screen.
        send(8'h0C, 1'b0);
        settle_and_check("ff");

`ifdef VRAM_TEXT_WRITER_HEX_EN
        send(8'hA7, 1'b1);
        settle_and_check("hex");
        check_eq("hex_col", {25'd0, cursor_col}, 3);
`endif

        // Randomized stream with idle gaps.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) b = 8'h0A;
            else if (r < 12) b = 8'h0D;
            else if (r < 18) b = 8'h08;
            else if (r < 19) b = 8'h0C;
            else if (r < 22) b = 8'($urandom_range(0, 7));
            else b = 8'($urandom_range(32, 255));
            hx = 1'b0;
`ifdef VRAM_TEXT_WRITER_HEX_EN
            hx = ($urandom_range(0, 4) == 0);
`endif
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(b, hx);
        end
        settle_and_check("rand");

        // Reset in the middle of a line clear restarts the full clear at 0.
        send(8'h0A, 1'b0);
        repeat (20) @(posedge clk);
        do_reset(1);
        wait_ready(low);
        check_eq("mid_rst_ready_low", low, CELLS);
        check_eq("mid_rst_pending", exp_addr_q.size(), 0);
        check_eq("mid_rst_col", {25'd0, cursor_col}, 0);
        check_eq("mid_rst_row", {27'd0, cursor_row}, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
